// File: rtl/rgb_led_sequencer.sv
// RGB status LED controller: synchronised and debounced KEY with short/long press
// classification, AUTO/MANUAL/OFF mode FSM, 4-step colour sequence and brightness PWM.
module rgb_led_sequencer #(
  parameter int STEP_CYCLES     = 100000000,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int LONG_CYCLES     = 200000000,
  parameter int PWM_BITS        = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                KEY,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic                LED_R,
  output logic                LED_G,
  output logic                LED_B,
  output logic [1:0]          MODE,
  output logic [1:0]          STATE,
  output logic                KEY_SHORT,
  output logic                KEY_LONG
);

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_OFF    = 2'd2
  } mode_e;

  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  localparam logic [1:0] COLOUR_RED   = 2'd1;
  localparam logic [1:0] COLOUR_GREEN = 2'd2;
  localparam logic [1:0] COLOUR_BLUE  = 2'd3;

  // Key input path
  logic [1:0]        sync_q;
  logic              key_s;
  logic              key_db;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_fired;
  logic              db_mismatch;
  logic              db_accept;
  logic              rel_evt;
  logic              long_evt;
  logic              short_evt;

  // Mode / colour sequencing
  mode_e             mode_q;
  mode_e             mode_d;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_d;

  // Brightness PWM
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic                lit;

  assign key_s       = sync_q[1];
  assign db_mismatch = (key_s != key_db);
  assign db_accept   = db_mismatch && (db_cnt == DB_LAST);
  assign rel_evt     = db_accept && key_s;
  // A release accepted on the very cycle the hold limit is reached counts as short.
  assign long_evt    = !key_db && (hold_cnt == HOLD_LAST) && !rel_evt;
  assign short_evt   = rel_evt && !long_fired;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= 2'b11;
      key_db     <= 1'b1;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      long_fired <= 1'b0;
      KEY_SHORT  <= 1'b0;
      KEY_LONG   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values,
      // which is what makes the two-flop synchroniser a real shift register.
      sync_q <= {sync_q[0], KEY};

      if (db_accept || !db_mismatch) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end

      if (db_accept) begin
        key_db <= key_s;
      end

      if (rel_evt) begin
        hold_cnt   <= '0;
        long_fired <= 1'b0;
      end else begin
        if (!key_db && (hold_cnt != HOLD_MAX)) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        if (long_evt) begin
          long_fired <= 1'b1;
        end
      end

      KEY_SHORT <= short_evt;
      KEY_LONG  <= long_evt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q   <= MODE_AUTO;
      state_q  <= 2'd0;
      step_cnt <= '0;
    end else begin
      mode_q   <= mode_d;
      state_q  <= state_d;
      step_cnt <= step_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    mode_d  = mode_q;
    state_d = state_q;
    step_d  = step_cnt;

    if (long_evt) begin
      // Mode change wins over a coincident AUTO wrap: STATE holds, step restarts.
      step_d = '0;
      case (mode_q)
        MODE_AUTO:   mode_d = MODE_MANUAL;
        MODE_MANUAL: mode_d = MODE_OFF;
        default:     mode_d = MODE_AUTO;
      endcase
    end else begin
      case (mode_q)
        MODE_AUTO: begin
          if (step_cnt == STEP_LAST) begin
            step_d  = '0;
            state_d = state_q + 2'd1;
          end else begin
            step_d = step_cnt + STEP_W'(1);
          end
        end
        MODE_MANUAL: begin
          step_d = '0;
          if (short_evt) begin
            state_d = state_q + 2'd1;
          end
        end
        MODE_OFF: begin
        end
        default: mode_d = MODE_AUTO;
      endcase
    end
  end

  assign MODE  = mode_q;
  assign STATE = state_q;

  // All-ones brightness must be fully on, which the compare alone cannot reach.
  assign pwm_on = (pwm_cnt < BRIGHT) || (&BRIGHT);
  assign lit    = (mode_q != MODE_OFF) && pwm_on;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt <= '0;
      LED_R   <= 1'b1;
      LED_G   <= 1'b1;
      LED_B   <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      LED_R   <= ~(lit && (state_q == COLOUR_RED));
      LED_G   <= ~(lit && (state_q == COLOUR_GREEN));
      LED_B   <= ~(lit && (state_q == COLOUR_BLUE));
    end
  end

endmodule
